reservation_station: RTL and testbench
======================================

# reservation_station

Holds issued instructions for one functional-unit class until their source operands are available, snooping the common data bus (CDB) broadcast of tag/value pairs to wake waiting operands. It sits between the issue stage and a functional unit (add, logic, mul, ...), on the receiving end of the CDB: the CDB broadcasts results, and each reservation station captures them. Ready entries are dispatched to the functional unit over a valid/ready handshake.

## Interface
- DEPTH, 3, number of entries (2..8)
- OP_W, 4, opcode width
- TAG_W, 5, tag width
- DATA_W, 32, operand width
- INVALID_TAG, 5'b11111, Q value meaning "operand value present"

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_issue  in  1  issue request, one instruction per cycle
- in_op  in  OP_W  opcode
- in_dest_tag  in  TAG_W  tag this instruction's result will carry on the CDB
- in_vj, in_vk  in  DATA_W  source operand values (valid when matching Q = INVALID_TAG)
- in_qj, in_qk  in  TAG_W  producer tags of the sources, INVALID_TAG if ready
- out_full  out  1  no free entry; issue ignored
- in_broadcast  in  1  CDB broadcast valid
- in_tag  in  TAG_W  CDB tag
- in_val  in  DATA_W  CDB value
- out_dispatch  out  1  an entry is ready for the FU
- out_op  out  OP_W  dispatched opcode
- out_vj, out_vk  out  DATA_W  dispatched operands
- out_dest_tag  out  TAG_W  dispatched destination tag
- in_fu_ready  in  1  FU accepts this cycle
- in_flush  in  1  synchronous clear of all entries

## Operation
- Per entry: busy, op, dest_tag, vj, qj, vk, qk. Entry is ready when busy and qj = qk = INVALID_TAG.
- Issue: when in_issue and !out_full, write into the lowest-index free entry; busy set.
- Issue-time forwarding: if in_broadcast and in_tag equals in_qj (or in_qk) and that Q is not INVALID_TAG, store in_val and INVALID_TAG instead of the issued pair.
- Snoop: every cycle with in_broadcast, each busy entry with qj = in_tag (qj ≠ INVALID_TAG) loads vj ← in_val, qj ← INVALID_TAG; same independently for k. Broadcast of INVALID_TAG matches nothing.
- Selection: lowest-index ready entry drives out_op/out_vj/out_vk/out_dest_tag; out_dispatch = any entry ready. Outputs are combinational from entry state; they are zero when out_dispatch is low.
- Handshake: out_dispatch && in_fu_ready at a rising edge frees the selected entry. Without in_fu_ready the same entry stays selected (stable outputs) unless a lower-index entry becomes ready.
- out_full = all entries busy (current state; a same-cycle dispatch does not make room for a same-cycle issue).
- in_flush: all busy cleared at next edge; issue in the same cycle is dropped; dispatch handshake in the same cycle still counts as accepted by the FU.
- Reset: all busy = 0, all Q = INVALID_TAG, V = 0; out_full = 0, out_dispatch = 0, out_op/out_vj/out_vk = 0, out_dest_tag = INVALID_TAG.

## Timing
- Issue with both sources ready: out_dispatch high the cycle after issue (earliest dispatch, 1-cycle latency).
- Broadcast at edge N wakes operand; entry dispatchable in cycle N+1 (never combinationally in cycle N).
- Issue and broadcast matching its source in the same cycle: captured, no lost wakeup.
- Simultaneous issue into entry k and dispatch of entry m (m ≠ k): both occur.
- One issue, one dispatch, one broadcast per cycle maximum.
- rst_n assertion mid-operation clears all entries immediately, no dispatch after release until a new issue.

## Structure
- Shared tomasulo package: INVALID_TAG, TAG_W, DATA_W, entry struct type (busy, op, dest_tag, vj, qj, vk, qk), shared with the CDB and the register status table.
- One sub-module natural: rs_entry (single-entry storage with snoop/forward compare logic); top does allocation, priority select, full flag.

## Test plan
- Reset, then issue op=2, dest=3, qj=qk=INVALID_TAG, vj=5, vk=7 -> next cycle out_dispatch=1, out_vj=5, out_vk=7, out_dest_tag=3; with in_fu_ready=1 entry freed, out_dispatch=0 after.
- Issue dest=1, qj=4, vk=9 ready; broadcast tag=4 val=0x10 two cycles later -> out_dispatch rises cycle after broadcast with out_vj=0x10.
- Issue qj=6 while in_broadcast tag=6 val=0xAA same cycle -> entry ready next cycle, out_vj=0xAA.
- Fill 3 entries with qj=7 -> out_full=1, 4th issue ignored; broadcast tag=7 -> entries dispatch in index order 0,1,2 across three accepted handshakes.
- Ready entry held with in_fu_ready=0 for 4 cycles -> outputs stable; then in_fu_ready=1 -> freed once only.
- Assert rst_n low mid-wait and separately in_flush with 2 busy entries -> out_full=0, out_dispatch=0, later broadcast of old tags wakes nothing.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared Tomasulo definitions: tag/data widths, the "operand present" tag,
// and the reservation-station entry record used by the RS, CDB and register status table.
package reservation_station_pkg;

  localparam int OP_W   = 4;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest_tag;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
  } rs_entry_t;

  localparam rs_entry_t RS_ENTRY_RESET = '{
    busy:     1'b0,
    op:       '0,
    dest_tag: INVALID_TAG,
    vj:       '0,
    qj:       INVALID_TAG,
    vk:       '0,
    qk:       INVALID_TAG
  };

  // A broadcast of INVALID_TAG must never match, since that Q means "value present".
  function automatic logic tag_hit(input logic [TAG_W-1:0] q,
                                   input logic [TAG_W-1:0] tag,
                                   input logic             broadcast);
    return broadcast && (q != INVALID_TAG) && (q == tag);
  endfunction

endpackage

// File: rtl/reservation_station_entry.sv
// Single reservation-station slot: holds one instruction and wakes its operands
// from the CDB, including a broadcast that coincides with the issue write.
module reservation_station_entry
  import reservation_station_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic              free,
  input  logic              flush,
  input  logic [OP_W-1:0]   op,
  input  logic [TAG_W-1:0]  dest_tag,
  input  logic [DATA_W-1:0] vj,
  input  logic [TAG_W-1:0]  qj,
  input  logic [DATA_W-1:0] vk,
  input  logic [TAG_W-1:0]  qk,
  input  logic              broadcast,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] val,
  output rs_entry_t         state,
  output logic              ready
);

  rs_entry_t ent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent <= RS_ENTRY_RESET;
    end else if (alloc) begin
      ent.busy     <= 1'b1;
      ent.op       <= op;
      ent.dest_tag <= dest_tag;
      if (tag_hit(qj, tag, broadcast)) begin
        ent.vj <= val;
        ent.qj <= INVALID_TAG;
      end else begin
        ent.vj <= vj;
        ent.qj <= qj;
      end
      if (tag_hit(qk, tag, broadcast)) begin
        ent.vk <= val;
        ent.qk <= INVALID_TAG;
      end else begin
        ent.vk <= vk;
        ent.qk <= qk;
      end
    end else begin
      if (flush || free) begin
        ent.busy <= 1'b0;
      end
      // Snoop only live entries so stale tags of freed slots never wake.
      if (ent.busy && tag_hit(ent.qj, tag, broadcast)) begin
        ent.vj <= val;
        ent.qj <= INVALID_TAG;
      end
      if (ent.busy && tag_hit(ent.qk, tag, broadcast)) begin
        ent.vk <= val;
        ent.qk <= INVALID_TAG;
      end
    end
  end

  assign state = ent;
  assign ready = ent.busy && (ent.qj == INVALID_TAG) && (ent.qk == INVALID_TAG);

endmodule

// File: rtl/reservation_station.sv
// Reservation station: allocates issued instructions into the lowest free slot
// and dispatches the lowest-index ready slot to the functional unit.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_issue,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TAG_W-1:0]  in_dest_tag,
  input  logic [DATA_W-1:0] in_vj,
  input  logic [DATA_W-1:0] in_vk,
  input  logic [TAG_W-1:0]  in_qj,
  input  logic [TAG_W-1:0]  in_qk,
  output logic              out_full,
  input  logic              in_broadcast,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_val,
  output logic              out_dispatch,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_vj,
  output logic [DATA_W-1:0] out_vk,
  output logic [TAG_W-1:0]  out_dest_tag,
  input  logic              in_fu_ready,
  input  logic              in_flush
);

  rs_entry_t          ent [DEPTH];
  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   ready;
  logic [DEPTH-1:0]   alloc_oh;
  logic [DEPTH-1:0]   sel_oh;
  logic [DEPTH-1:0]   free_oh;
  logic               issue_en;
  logic               alloc_found;
  logic               sel_found;

  // Full reflects current occupancy; a slot freed this cycle is reusable only next cycle.
  assign out_full     = &busy;
  assign out_dispatch = |ready;
  assign issue_en     = in_issue && !out_full && !in_flush;
  assign free_oh      = (out_dispatch && in_fu_ready) ? sel_oh : '0;

  always_comb begin
    alloc_oh    = '0;
    sel_oh      = '0;
    alloc_found = 1'b0;
    sel_found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
      if (ready[i] && !sel_found) begin
        sel_oh[i] = 1'b1;
        sel_found = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    reservation_station_entry u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc     (issue_en && alloc_oh[g]),
      .free      (free_oh[g]),
      .flush     (in_flush),
      .op        (in_op),
      .dest_tag  (in_dest_tag),
      .vj        (in_vj),
      .qj        (in_qj),
      .vk        (in_vk),
      .qk        (in_qk),
      .broadcast (in_broadcast),
      .tag       (in_tag),
      .val       (in_val),
      .state     (ent[g]),
      .ready     (ready[g])
    );
    assign busy[g] = ent[g].busy;
  end

  // Idle outputs read as zero operands with the "no tag" destination.
  always_comb begin
    out_op       = '0;
    out_vj       = '0;
    out_vk       = '0;
    out_dest_tag = INVALID_TAG;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        out_op       = ent[i].op;
        out_vj       = ent[i].vj;
        out_vk       = ent[i].vk;
        out_dest_tag = ent[i].dest_tag;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: hand-derived vector table, flush/reset sequences,
// and randomized traffic against an array-based reference model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int DEPTH = 3;
  localparam logic [TAG_W-1:0] INV = INVALID_TAG;

  logic              clk, rst_n;
  logic              in_issue, in_broadcast, in_fu_ready, in_flush;
  logic [OP_W-1:0]   in_op, out_op;
  logic [TAG_W-1:0]  in_dest_tag, in_qj, in_qk, in_tag, out_dest_tag;
  logic [DATA_W-1:0] in_vj, in_vk, in_val, out_vj, out_vk;
  logic              out_full, out_dispatch;

  reservation_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_issue(in_issue), .in_op(in_op),
    .in_dest_tag(in_dest_tag), .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj),
    .in_qk(in_qk), .out_full(out_full), .in_broadcast(in_broadcast),
    .in_tag(in_tag), .in_val(in_val), .out_dispatch(out_dispatch),
    .out_op(out_op), .out_vj(out_vj), .out_vk(out_vk),
    .out_dest_tag(out_dest_tag), .in_fu_ready(in_fu_ready), .in_flush(in_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [74:0] obs_t;  // {dispatch, full, op, dest_tag, vj, vk}

  typedef struct {
    logic              issue;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
    logic              bc;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    logic              fu;
    logic              fl;
    obs_t              exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain arrays of entries updated by the textual rules.
  logic              m_busy [DEPTH];
  logic [OP_W-1:0]   m_op   [DEPTH];
  logic [TAG_W-1:0]  m_dest [DEPTH];
  logic [DATA_W-1:0] m_vj   [DEPTH];
  logic [TAG_W-1:0]  m_qj   [DEPTH];
  logic [DATA_W-1:0] m_vk   [DEPTH];
  logic [TAG_W-1:0]  m_qk   [DEPTH];

  function automatic obs_t ex(logic d, logic f, logic [OP_W-1:0] op, logic [TAG_W-1:0] dst,
                              logic [DATA_W-1:0] vj, logic [DATA_W-1:0] vk);
    return {d, f, op, dst, vj, vk};
  endfunction

  function automatic vec_t row(logic iss, logic [OP_W-1:0] op, logic [TAG_W-1:0] dest,
                               logic [DATA_W-1:0] vj, logic [TAG_W-1:0] qj,
                               logic [DATA_W-1:0] vk, logic [TAG_W-1:0] qk,
                               logic bc, logic [TAG_W-1:0] tag, logic [DATA_W-1:0] val,
                               logic fu, logic fl, obs_t exp);
    vec_t v;
    v.issue = iss; v.op = op; v.dest = dest; v.vj = vj; v.qj = qj; v.vk = vk; v.qk = qk;
    v.bc = bc; v.tag = tag; v.val = val; v.fu = fu; v.fl = fl; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t idle(logic fu);
    return row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, fu, 0, '0);
  endfunction

  function automatic obs_t dut_out();
    return {out_dispatch, out_full, out_op, out_dest_tag, out_vj, out_vk};
  endfunction

  function automatic obs_t model_out();
    int sel = -1;
    logic full = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_busy[i]) full = 1'b0;
      if (sel < 0 && m_busy[i] && m_qj[i] == INV && m_qk[i] == INV) sel = i;
    end
    if (sel < 0) return ex(1'b0, full, '0, INV, '0, '0);
    return ex(1'b1, full, m_op[sel], m_dest[sel], m_vj[sel], m_vk[sel]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0; m_op[i] = 0; m_dest[i] = INV;
      m_vj[i] = 0; m_qj[i] = INV; m_vk[i] = 0; m_qk[i] = INV;
    end
  endtask

  task automatic model_step();
    int sel = -1;
    int fr = -1;
    logic full = 1'b1;
    logic hit;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_busy[i]) full = 1'b0;
      if (fr < 0 && !m_busy[i]) fr = i;
      if (sel < 0 && m_busy[i] && m_qj[i] == INV && m_qk[i] == INV) sel = i;
    end
    hit = in_broadcast && in_tag != INV;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && hit && m_qj[i] == in_tag) begin m_vj[i] = in_val; m_qj[i] = INV; end
      if (m_busy[i] && hit && m_qk[i] == in_tag) begin m_vk[i] = in_val; m_qk[i] = INV; end
    end
    if (sel >= 0 && in_fu_ready) m_busy[sel] = 0;
    if (in_flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    end else if (in_issue && !full) begin
      m_busy[fr] = 1; m_op[fr] = in_op; m_dest[fr] = in_dest_tag;
      if (hit && in_qj == in_tag) begin m_vj[fr] = in_val; m_qj[fr] = INV; end
      else begin m_vj[fr] = in_vj; m_qj[fr] = in_qj; end
      if (hit && in_qk == in_tag) begin m_vk[fr] = in_val; m_qk[fr] = INV; end
      else begin m_vk[fr] = in_vk; m_qk[fr] = in_qk; end
    end
  endtask

  task automatic chk(string name, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    in_issue = v.issue; in_op = v.op; in_dest_tag = v.dest;
    in_vj = v.vj; in_qj = v.qj; in_vk = v.vk; in_qk = v.qk;
    in_broadcast = v.bc; in_tag = v.tag; in_val = v.val;
    in_fu_ready = v.fu; in_flush = v.fl;
  endtask

  task automatic tick(string name);
    model_step();
    @(posedge clk);
    #1;
    chk(name, dut_out(), model_out());
  endtask

  function automatic logic [TAG_W-1:0] rnd_tag();
    int r = $urandom_range(0, 4);
    return (r == 4) ? INV : TAG_W'(r);
  endfunction

  vec_t tbl[$];
  obs_t E, F;

  initial begin
    E = ex(0, 0, 0, INV, 0, 0);
    F = ex(0, 1, 0, INV, 0, 0);
    // Basic ready issue, then accept
    tbl.push_back(row(1, 2, 3, 5, INV, 7, INV, 0, 0, 0, 0, 0, ex(1, 0, 2, 3, 5, 7)));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, E));
    // Wake by later broadcast
    tbl.push_back(row(1, 1, 1, 0, 4, 9, INV, 0, 0, 0, 0, 0, E));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 0, 0, E));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 1, 4, 32'h10, 0, 0, ex(1, 0, 1, 1, 32'h10, 9)));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, E));
    // Same-cycle issue and broadcast
    tbl.push_back(row(1, 3, 2, 0, 6, 1, INV, 1, 6, 32'hAA, 0, 0, ex(1, 0, 3, 2, 32'hAA, 1)));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, E));
    // Fill, overflow issue ignored, wake all, drain in index order
    tbl.push_back(row(1, 4, 8, 0, 7, 1, INV, 0, 0, 0, 0, 0, E));
    tbl.push_back(row(1, 5, 9, 0, 7, 2, INV, 0, 0, 0, 0, 0, E));
    tbl.push_back(row(1, 6, 10, 0, 7, 3, INV, 0, 0, 0, 0, 0, F));
    tbl.push_back(row(1, 7, 11, 1, INV, 1, INV, 0, 0, 0, 0, 0, F));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 1, 7, 32'h77, 0, 0, ex(1, 1, 4, 8, 32'h77, 1)));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, ex(1, 0, 5, 9, 32'h77, 2)));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, ex(1, 0, 6, 10, 32'h77, 3)));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, E));
    // Held without FU ready, then freed exactly once
    tbl.push_back(row(1, 9, 12, 32'h21, INV, 32'h22, INV, 0, 0, 0, 0, 0, ex(1, 0, 9, 12, 32'h21, 32'h22)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 0, 0, ex(1, 0, 9, 12, 32'h21, 32'h22)));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, E));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, E));
    // Issue into slot 1 while slot 0 dispatches
    tbl.push_back(row(1, 10, 13, 1, INV, 2, INV, 0, 0, 0, 0, 0, ex(1, 0, 10, 13, 1, 2)));
    tbl.push_back(row(1, 11, 14, 3, INV, 4, INV, 0, 0, 0, 1, 0, ex(1, 0, 11, 14, 3, 4)));
    tbl.push_back(row(0, 0, 0, 0, INV, 0, INV, 0, 0, 0, 1, 0, E));

    drive(idle(0));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_state", dut_out(), E);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick($sformatf("model_vec%0d", i));
      chk($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Flush with two waiting entries; same-cycle issue is dropped
    drive(row(1, 1, 5, 0, 20, 0, INV, 0, 0, 0, 0, 0, E)); tick("flush_fill0");
    drive(row(1, 2, 6, 0, 21, 0, INV, 0, 0, 0, 0, 0, E)); tick("flush_fill1");
    drive(row(1, 3, 7, 1, INV, 1, INV, 0, 0, 0, 0, 1, E)); tick("flush_model");
    chk("flush_clear", dut_out(), E);
    drive(row(0, 0, 0, 0, INV, 0, INV, 1, 20, 32'h5, 0, 0, E)); tick("flush_old_tag");
    chk("flush_no_wake", dut_out(), E);

    // Asynchronous reset while entries wait
    drive(row(1, 4, 8, 0, 22, 0, INV, 0, 0, 0, 0, 0, E)); tick("rst_fill0");
    drive(row(1, 5, 9, 0, 22, 0, INV, 0, 0, 0, 0, 0, E)); tick("rst_fill1");
    drive(idle(0));
    rst_n = 1'b0;
    #2;
    chk("rst_async", dut_out(), E);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(row(0, 0, 0, 0, INV, 0, INV, 1, 22, 32'h9, 1, 0, E)); tick("rst_old_tag");
    chk("rst_no_wake", dut_out(), E);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_issue     = ($urandom_range(0, 1) == 1);
      in_op        = OP_W'($urandom);
      in_dest_tag  = TAG_W'($urandom);
      in_vj        = $urandom;
      in_vk        = $urandom;
      in_qj        = rnd_tag();
      in_qk        = rnd_tag();
      in_broadcast = ($urandom_range(0, 1) == 1);
      in_tag       = rnd_tag();
      in_val       = $urandom;
      in_fu_ready  = ($urandom_range(0, 2) != 0);
      in_flush     = ($urandom_range(0, 39) == 0);
      tick($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
